// File: rtl/mux_4to1_8b.sv
// Registered 4:1 mux: captures the {sel2,sel1}-selected source on en, with a change pulse.
// Latency 1 cycle; no backpressure, en=0 simply holds result and sel_q.
module mux_4to1_8b #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             en,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       sel_q,
  output logic             changed
);

  logic [1:0]       w_idx;
  logic [WIDTH-1:0] w_sel;
  logic             w_diff;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_sel_q;
  logic             r_changed;

  assign w_idx = {sel2, sel1};

  // An X/Z select matches no case item, so the default propagates X rather than picking a source.
  always_comb begin
    w_sel = {WIDTH{1'bx}};
    case (w_idx)
      2'b00:   w_sel = a;
      2'b01:   w_sel = b;
      2'b10:   w_sel = c;
      2'b11:   w_sel = d;
      default: w_sel = {WIDTH{1'bx}};
    endcase
  end

  assign w_diff = (w_sel != r_result);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result  <= '0;
      r_sel_q   <= 2'b00;
      r_changed <= 1'b0;
    end else begin
      r_changed <= en & w_diff;
      if (en) begin
        r_result <= w_sel;
        r_sel_q  <= w_idx;
      end
    end
  end

  assign result  = r_result;
  assign sel_q   = r_sel_q;
  assign changed = r_changed;

endmodule

// File: tb/tb_mux_4to1_8b.sv
// Directed-vector bench for mux_4to1_8b; expected values are hand-computed constants.
module tb_mux_4to1_8b;

  logic       clk;
  logic       rst;
  logic [7:0] a, b, c, d;
  logic       sel1, sel2, en;
  logic [7:0] result;
  logic [1:0] sel_q;
  logic       changed;

  int n_checks = 0;
  int n_errors = 0;

  mux_4to1_8b #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .sel1    (sel1),
    .sel2    (sel2),
    .en      (en),
    .result  (result),
    .sel_q   (sel_q),
    .changed (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] r, input logic [1:0] s,
                           input logic ch);
    check({tag, ".result"},  result,          r);
    check({tag, ".sel_q"},   {6'd0, sel_q},   {6'd0, s});
    check({tag, ".changed"}, {7'd0, changed}, {7'd0, ch});
  endtask

  // Advance past one rising edge and settle, so sampling and driving happen between edges.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a = 8'h00; b = 8'hF0; c = 8'h0F; d = 8'hFF;
    sel2 = 1'b0; sel1 = 1'b0; en = 1'b1;
    #2;
    check_all("rst_init", 8'h00, 2'd0, 1'b0);
    step();
    check_all("rst_edge", 8'h00, 2'd0, 1'b0);

    rst = 1'b0;
    step();
    check_all("sel00", 8'h00, 2'd0, 1'b0);

    sel1 = 1'b1;
    step();
    check_all("sel01", 8'hF0, 2'd1, 1'b1);
    step();
    check_all("sel01_hold", 8'hF0, 2'd1, 1'b0);

    sel2 = 1'b1; sel1 = 1'b0;
    step();
    check_all("sel10", 8'h0F, 2'd2, 1'b1);

    sel1 = 1'b1;
    step();
    check_all("sel11", 8'hFF, 2'd3, 1'b1);

    en = 1'b0; sel2 = 1'b0; sel1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("en0_%0d", i), 8'hFF, 2'd3, 1'b0);
    end

    // Inputs moving between edges must not reach the outputs.
    en = 1'b1;
    #2;
    check_all("between_edges", 8'hFF, 2'd3, 1'b0);
    step();
    check_all("recapture00", 8'h00, 2'd0, 1'b1);

    sel2 = 1'b1; sel1 = 1'b1;
    step();
    check_all("back_to_ff", 8'hFF, 2'd3, 1'b1);

    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 8'h00, 2'd0, 1'b0);
    step();
    check_all("rst_over_en", 8'h00, 2'd0, 1'b0);

    rst = 1'b0;
    step();
    check_all("post_rst", 8'hFF, 2'd3, 1'b1);

    a = 8'h5A; b = 8'h5A; sel2 = 1'b0; sel1 = 1'b0;
    step();
    check_all("same_a", 8'h5A, 2'd0, 1'b1);
    step();
    check_all("same_a_hold", 8'h5A, 2'd0, 1'b0);
    sel1 = 1'b1;
    step();
    check_all("same_b", 8'h5A, 2'd1, 1'b0);

    c = 8'h81; sel2 = 1'b1; sel1 = 1'b0;
    step();
    check_all("bits_c", 8'h81, 2'd2, 1'b1);
    d = 8'h3C; sel1 = 1'b1;
    step();
    check_all("bits_d", 8'h3C, 2'd3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_4to1_8b.md
MUX_4TO1_8B -- requirements
Module: mux_4to1_8b

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the data width of inputs a/b/c/d and output result.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port a, input, WIDTH bits: source 0.
REQ-005 The block SHALL have port b, input, WIDTH bits: source 1.
REQ-006 The block SHALL have port c, input, WIDTH bits: source 2.
REQ-007 The block SHALL have port d, input, WIDTH bits: source 3.
REQ-008 The block SHALL have port sel1, input, 1 bit: select LSB.
REQ-009 The block SHALL have port sel2, input, 1 bit: select MSB.
REQ-010 The block SHALL have port en, input, 1 bit: capture enable, active-high.
REQ-011 The block SHALL have port result, output, WIDTH bits: registered selected data.
REQ-012 The block SHALL have port sel_q, output, 2 bits: registered select index {sel2,sel1} that produced result.
REQ-013 The block SHALL have port changed, output, 1 bit: one-cycle pulse when result takes a new value.

Function
REQ-014 The select index SHALL be idx = {sel2, sel1}, with mapping: 00 -> a, 01 (sel1=1) -> b, 10 (sel2=1) -> c, 11 -> d.
REQ-015 Selection SHALL be purely combinational ahead of the output register, with no priority between sources.
REQ-016 On a rising clk edge with en=1, result SHALL load the selected source and sel_q SHALL load idx; latency is 1 cycle.
REQ-017 On a rising clk edge with en=0, result and sel_q SHALL hold their values.
REQ-018 On each rising clk edge, changed SHALL be set to 1 when en=1 and the selected source differs from the current result; otherwise it SHALL be set to 0.
REQ-019 A change of idx with identical data (e.g., a=b) SHALL update sel_q but SHALL NOT assert changed.
REQ-020 Changes on a-d or sel1/sel2 between clock edges SHALL NOT affect the outputs until the next capturing edge.
REQ-021 The data path SHALL be bit-exact: no inversion, extension, or truncation of any bit for any WIDTH >= 1.
REQ-022 If any select bit is X/Z, the captured result SHALL be X; no source SHALL be silently defaulted.

Reset
REQ-023 While rst=1, result SHALL be 0, sel_q SHALL be 2'b00, and changed SHALL be 0, immediately and independent of clk.
REQ-024 Reset asserted mid-operation SHALL override en and any pending capture.
REQ-025 On the first rising edge after rst deasserts, normal capture per REQ-016 to REQ-018 SHALL resume.

Verification
REQ-026 With a=00, b=F0, c=0F, d=FF and en=1, sel2/sel1=0/0, the bench SHALL see result=00, sel_q=0, changed=0 one edge after reset release.
REQ-027 With the same data and sel2/sel1=0/1, the bench SHALL see result=F0, sel_q=1, changed=1 for exactly one cycle.
REQ-028 With the same data and sel2/sel1=1/0, the bench SHALL see result=0F, sel_q=2; with sel2/sel1=1/1, the bench SHALL see result=FF, sel_q=3.
REQ-029 With result=FF, setting en=0 and select 0/0 for 3 edges, the bench SHALL see result=FF and changed=0 throughout.
REQ-030 Asserting rst between clock edges while result=FF SHALL clear result to 00 and sel_q to 0 before the next edge.
REQ-031 With a=b=5A and select toggled 00 -> 01, the bench SHALL see sel_q 0 -> 1 with result=5A and changed=0.
